fuzzy_dim_reducer: RTL and testbench

Sequential N-dimension membership reducer for the fuzzy controller datapath. It folds NUM_DIMS (membership value, region flag) pairs into one cut-limited value and one combined flag, one dimension per cycle, using the pairwise cut/flag rule of the existing two-dimension reducer. Valid/ready handshakes sit on both sides, between the fuzzifier stage and the rule/defuzzify stage.

---
 rtl/fuzzy_pkg.sv | 30 +++
 rtl/fuzzy_cut_pair.sv | 31 +++
 rtl/fuzzy_dim_reducer.sv | 166 ++++++++++++++++
 tb/tb_fuzzy_dim_reducer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// ---------------------------------------------------------------------------
// fuzzy_pkg: shared flag constants, reducer state type and flag-combine rule
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fuzzy_pkg;

  localparam int FLAG_NEG  = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_POS  = 2;

  localparam logic [3:0] FLAG_CONFLICT = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Opposite-sign regions cancel into the zero region; otherwise regions merge.
  function automatic logic [3:0] flag_combine(input logic [3:0] a, input logic [3:0] b);
    logic conflict;
    conflict = (a[FLAG_NEG] & b[FLAG_POS]) | (a[FLAG_POS] & b[FLAG_NEG]);
    return conflict ? FLAG_CONFLICT : (a | b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fuzzy_cut_pair.sv
// ---------------------------------------------------------------------------
// fuzzy_cut_pair: combinational min-then-clip of two memberships plus flag merge
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fuzzy_cut_pair
  import fuzzy_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] cut_line_i,
  input  logic [3:0]       flag_a_i,
  input  logic [3:0]       flag_b_i,
  output logic [WIDTH-1:0] dim_o,
  output logic [3:0]       flag_o
);

  logic [WIDTH-1:0] min_d;

  always_comb begin
    min_d  = (a_i < b_i) ? a_i : b_i;
    dim_o  = (min_d > cut_line_i) ? cut_line_i : min_d;
    flag_o = flag_combine(flag_a_i, flag_b_i);
  end

endmodule

`default_nettype wire

// File: rtl/fuzzy_dim_reducer.sv
// ---------------------------------------------------------------------------
// fuzzy_dim_reducer: folds NUM_DIMS membership/flag pairs, one per cycle, into
// one cut-limited, scaled membership and a combined flag. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fuzzy_dim_reducer
  import fuzzy_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int NUM_DIMS = 4,
  parameter int OFFSET   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [WIDTH-1:0]          cut_line_i,
  input  logic [NUM_DIMS-1:0]       dim_mask_i,
  input  logic [4*NUM_DIMS-1:0]     dim_flags_i,
  input  logic [WIDTH*NUM_DIMS-1:0] dims_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [3:0]                out_flag_o,
  output logic [WIDTH-1:0]          out_dim_o
);

  localparam int              IDX_W    = $clog2(NUM_DIMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIMS - 1);
  localparam int              SHR      = -OFFSET;

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [WIDTH-1:0]          acc_q;
  logic [3:0]                accflag_q;
  logic [WIDTH-1:0]          cut_q;
  logic [NUM_DIMS-1:0]       mask_q;
  logic [4*NUM_DIMS-1:0]     flags_q;
  logic [WIDTH*NUM_DIMS-1:0] dims_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic [3:0]                out_flag_q;
  logic [WIDTH-1:0]          out_dim_q;

  logic [WIDTH-1:0] sel_dim_d;
  logic [3:0]       sel_flag_d;
  logic             sel_mask_d;
  logic [WIDTH-1:0] pair_dim_d;
  logic [3:0]       pair_flag_d;
  logic [WIDTH-1:0] fold_acc_d;
  logic [3:0]       fold_flag_d;
  logic [WIDTH-1:0] scaled_d;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] first_clip_d;

  always_comb begin
    sel_dim_d  = '0;
    sel_flag_d = '0;
    sel_mask_d = 1'b0;
    for (int i = 0; i < NUM_DIMS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_dim_d  = dims_q[WIDTH*i +: WIDTH];
        sel_flag_d = flags_q[4*i +: 4];
        sel_mask_d = mask_q[i];
      end
    end
  end

  fuzzy_cut_pair #(
    .WIDTH (WIDTH)
  ) u_pair (
    .a_i        (acc_q),
    .b_i        (sel_dim_d),
    .cut_line_i (cut_q),
    .flag_a_i   (accflag_q),
    .flag_b_i   (sel_flag_d),
    .dim_o      (pair_dim_d),
    .flag_o     (pair_flag_d)
  );

  // Masked-off dimensions still take their cycle so latency stays fixed.
  assign fold_acc_d   = sel_mask_d ? pair_dim_d  : acc_q;
  assign fold_flag_d  = sel_mask_d ? pair_flag_d : accflag_q;
  assign first_clip_d = (dims_i[WIDTH-1:0] > cut_line_i) ? cut_line_i : dims_i[WIDTH-1:0];

  generate
    if (OFFSET >= WIDTH) begin : g_shl_all
      assign scaled_d = (|fold_acc_d) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end else if (OFFSET > 0) begin : g_shl
      assign scaled_d = (|fold_acc_d[WIDTH-1 -: OFFSET]) ? {WIDTH{1'b1}}
                                                        : (fold_acc_d << OFFSET);
    end else if (SHR >= WIDTH) begin : g_shr_all
      assign scaled_d = {WIDTH{1'b0}};
    end else if (SHR > 0) begin : g_shr
      assign scaled_d = fold_acc_d >> SHR;
    end else begin : g_none
      assign scaled_d = fold_acc_d;
    end
  endgenerate

  assign result_d = fold_flag_d[FLAG_ZERO] ? fold_acc_d : scaled_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      accflag_q   <= '0;
      cut_q       <= '0;
      mask_q      <= '0;
      flags_q     <= '0;
      dims_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_flag_q  <= '0;
      out_dim_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            dims_q     <= dims_i;
            flags_q    <= dim_flags_i;
            mask_q     <= dim_mask_i;
            cut_q      <= cut_line_i;
            acc_q      <= first_clip_d;
            accflag_q  <= dim_flags_i[3:0];
            idx_q      <= IDX_W'(1);
            in_ready_q <= 1'b0;
            state_q    <= ST_FOLD;
          end
        end
        ST_FOLD: begin
          acc_q     <= fold_acc_d;
          accflag_q <= fold_flag_d;
          idx_q     <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            out_dim_q   <= result_d;
            out_flag_q  <= fold_flag_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_flag_o  = out_flag_q;
  assign out_dim_o   = out_dim_q;

endmodule

`default_nettype wire

// File: tb/tb_fuzzy_dim_reducer.sv
// ---------------------------------------------------------------------------
// tb_fuzzy_dim_reducer: two lockstep reducers (OFFSET=1 and OFFSET=-2) against
// an arithmetic reference model. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fuzzy_dim_reducer;

  localparam int WIDTH = 10;
  localparam int ND    = 3;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic [WIDTH-1:0]    cut_line = '0;
  logic [ND-1:0]       dim_mask = '0;
  logic [4*ND-1:0]     dim_flags = '0;
  logic [WIDTH*ND-1:0] dims = '0;

  logic                in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [3:0]          out_flag_a, out_flag_b;
  logic [WIDTH-1:0]    out_dim_a, out_dim_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fuzzy_dim_reducer #(.WIDTH(WIDTH), .NUM_DIMS(ND), .OFFSET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .cut_line_i(cut_line), .dim_mask_i(dim_mask), .dim_flags_i(dim_flags),
    .dims_i(dims), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .out_flag_o(out_flag_a), .out_dim_o(out_dim_a)
  );

  fuzzy_dim_reducer #(.WIDTH(WIDTH), .NUM_DIMS(ND), .OFFSET(-2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .cut_line_i(cut_line), .dim_mask_i(dim_mask), .dim_flags_i(dim_flags),
    .dims_i(dims), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .out_flag_o(out_flag_b), .out_dim_o(out_dim_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Reference: fold with min/cut and region rule, then scale if not in zero region.
  function automatic int ref_fold(input int dv[ND], input int fv[ND], input int m,
                                  input int cut, output int flag);
    int acc;
    acc  = min3(dv[0], cut, MAXV);
    flag = fv[0];
    for (int k = 1; k < ND; k++) begin
      if (((m >> k) & 1) != 0) begin
        acc = min3(acc, dv[k], cut);
        if ((((flag & 1) != 0) && ((fv[k] & 4) != 0)) ||
            (((flag & 4) != 0) && ((fv[k] & 1) != 0)))
          flag = 2;
        else
          flag = flag | fv[k];
      end
    end
    return acc;
  endfunction

  function automatic int ref_scale(input int acc, input int flag, input int off);
    int v;
    if ((flag & 2) != 0) return acc;
    if (off > 0) begin
      v = acc * (1 << off);
      return (v > MAXV) ? MAXV : v;
    end
    if (off < 0) return acc / (1 << (-off));
    return acc;
  endfunction

  task automatic load_inputs(input int dv[ND], input int fv[ND], input int m, input int cut);
    for (int k = 0; k < ND; k++) begin
      dims[WIDTH*k +: WIDTH] = dv[k][WIDTH-1:0];
      dim_flags[4*k +: 4]    = fv[k][3:0];
    end
    dim_mask = m[ND-1:0];
    cut_line = cut[WIDTH-1:0];
  endtask

  task automatic scramble_inputs();
    dims      = WIDTH*ND'($urandom);
    dim_flags = 4*ND'($urandom);
    dim_mask  = ND'($urandom);
    cut_line  = WIDTH'($urandom);
  endtask

  task automatic run_txn(input int dv[ND], input int fv[ND], input int m, input int cut,
                         input int hold);
    int flag, acc, exp_a, exp_b, lat;
    acc   = ref_fold(dv, fv, m, cut, flag);
    exp_a = ref_scale(acc, flag, 1);
    exp_b = ref_scale(acc, flag, -2);
    check("ready_before_accept", int'(in_ready_a), 1);
    load_inputs(dv, fv, m, cut);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (!out_valid_a && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, ND - 1);
    check("dim_a", int'(out_dim_a), exp_a);
    check("flag_a", int'(out_flag_a), flag);
    check("dim_b", int'(out_dim_b), exp_b);
    check("flag_b", int'(out_flag_b), flag);
    check("valid_b", int'(out_valid_b), 1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      scramble_inputs();
      @(posedge clk); #1;
      check("hold_valid", int'(out_valid_a), 1);
      check("hold_dim", int'(out_dim_a), exp_a);
      check("hold_flag", int'(out_flag_a), flag);
      check("hold_ready", int'(in_ready_a), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", int'(out_valid_a), 0);
    check("release_ready", int'(in_ready_a), 1);
    check("keep_dim_b", int'(out_dim_b), exp_b);
  endtask

  initial begin
    int dv[ND];
    int fv[ND];

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid_a), 0);
    check("rst_dim", int'(out_dim_a), 0);
    check("rst_flag", int'(out_flag_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", int'(in_ready_a), 1);

    dv = '{100, 200, 300};  fv = '{1, 1, 1};  run_txn(dv, fv, 7, 1023, 0);
    dv = '{500, 400, 600};  fv = '{1, 4, 1};  run_txn(dv, fv, 7, 350, 1);
    dv = '{800, 900, 1000}; fv = '{4, 4, 4};  run_txn(dv, fv, 7, 1023, 0);
    dv = '{50, 10, 70};     fv = '{1, 1, 1};  run_txn(dv, fv, 5, 1023, 0);
    dv = '{300, 250, 700};  fv = '{4, 1, 4};  run_txn(dv, fv, 7, 900, 5);

    // Asynchronous reset in the middle of a fold abandons the transaction.
    dv = '{600, 500, 400}; fv = '{4, 4, 4};
    load_inputs(dv, fv, 7, 1023);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid_a), 0);
    check("mid_rst_dim", int'(out_dim_a), 0);
    check("mid_rst_flag", int'(out_flag_a), 0);
    check("mid_rst_dim_b", int'(out_dim_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", int'(in_ready_b), 1);
    dv = '{400, 1000, 900}; fv = '{4, 4, 4}; run_txn(dv, fv, 7, 1023, 0);

    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < ND; k++) begin
        dv[k] = $urandom_range(0, MAXV);
        fv[k] = $urandom_range(0, 15);
      end
      run_txn(dv, fv, $urandom_range(0, 7), $urandom_range(0, MAXV), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
